spi_register_bridge: RTL
========================

SPI_REGISTER_BRIDGE -- requirements
Module: spi_register_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages on each SPI input before edge detection (minimum 2).
REQ-002 i_Clock  input  1  system clock; all logic on its rising edge.
REQ-003 i_Reset  input  1  reset, synchronous, active-high.
REQ-004 i_SPI_SCK  input  1  SPI clock from host, asynchronous, mode 0 (CPOL=0, CPHA=0).
REQ-005 i_SPI_CS_n  input  1  SPI chip select, asynchronous, active-low; frames the transfer.
REQ-006 i_SPI_MOSI  input  1  host-to-block serial data, MSB first.
REQ-007 o_SPI_MISO  output  1  block-to-host serial data, MSB first; driven 0 when not shifting (no tristate).
REQ-008 i_Sample  input  16  signed audio sample from the synthesizer core.
REQ-009 i_SampleReady  input  1  one-cycle strobe; i_Sample valid in that cycle.
REQ-010 o_RegisterWriteEnable  output  1  one-cycle register write strobe to the synthesizer core.
REQ-011 o_RegisterWriteNumber  output  16  register number, SS PPPPPP OOO VVVVV layout, passed through unmodified.
REQ-012 o_RegisterWriteValue  output  8  register write data.
REQ-013 o_FrameError  output  1  one-cycle strobe on a malformed frame.

Function
REQ-014 Each SPI input SHALL pass through SYNC_STAGES flops; a further flop on SCK and CS_n SHALL give the previous value for edge detection.
REQ-015 An SCK rise SHALL be detected when the synchronized SCK is 1 and the previous value is 0; an SCK fall, a CS fall and a CS rise SHALL be detected the same way.
REQ-016 Correct operation SHALL be guaranteed for SCK high and low times of at least 4 i_Clock periods each.
REQ-017 FSM states: IDLE, SHIFT, DONE, WAIT_CS_HIGH.
REQ-018 IDLE: on CS fall go to SHIFT, clear the bit counter (5 bits) and load the MISO shift register; all other events are ignored.
REQ-019 SHIFT: on each SCK rise shift synchronized MOSI into bit 0 of a 24-bit shift register and increment the counter.
REQ-020 SHIFT: when the 24th SCK rise is detected in cycle N, the block SHALL go to DONE and drive o_RegisterWriteEnable=1 in cycle N+1 only.
REQ-021 Frame format: bits[23:8] go to o_RegisterWriteNumber and bits[7:0] go to o_RegisterWriteValue; both are updated in cycle N+1 and held until the next write.
REQ-022 SHIFT: a CS rise before 24 bits SHALL discard the frame, produce no write, pulse o_FrameError for 1 cycle and return to IDLE.
REQ-023 DONE: further SCK rises SHALL be ignored; the first extra rise SHALL set an overrun flag. On CS rise, pulse o_FrameError if the overrun flag is set, then go to IDLE.
REQ-024 WAIT_CS_HIGH: the block SHALL ignore all events until the synchronized CS_n is 1, then go to IDLE.
REQ-025 Sample hold register: load i_Sample on every cycle with i_SampleReady=1.
REQ-026 MISO load: on CS fall, the 16-bit MISO shift register SHALL load the hold register; if i_SampleReady=1 in the same cycle, it SHALL load i_Sample instead (bypass).
REQ-027 o_SPI_MISO SHALL equal bit 15 of the MISO shift register while in SHIFT or DONE, and 0 otherwise.
REQ-028 The MISO shift register SHALL shift left with 0 fill on each SCK fall; after 16 falls it outputs 0.
REQ-029 A CS rise and an SCK rise detected in the same cycle SHALL be treated as the CS rise only; that SCK rise is not counted.

Reset
REQ-030 While i_Reset=1: all outputs 0, hold register 0, shift registers and counter 0, overrun flag 0, synchronizer flops 1 for CS_n and 0 for SCK and MOSI.
REQ-031 After reset the FSM SHALL enter WAIT_CS_HIGH, so a frame in progress during reset is never decoded; no write strobe is issued from it.

Verification
REQ-032 SCK = i_Clock/8; frame 0xC00C_5A, CS held low for 24 bits -> exactly one o_RegisterWriteEnable pulse with number 0xC00C and value 0x5A, 1 cycle after the 24th rise is detected; o_FrameError stays 0.
REQ-033 Pulse i_SampleReady with i_Sample=0x8001, then run a frame -> MISO bits 1000_0000_0000_0001 on the first 16 SCK rises, then 8 zeros.
REQ-034 CS goes high after 13 bits -> no write strobe, one o_FrameError pulse, number and value keep their previous values; the next 24-bit frame writes correctly.
REQ-035 26 SCK rises in one frame with 0xA0_0001 in the first 24 bits -> write of number 0xA000, value 0x01 after bit 24; o_FrameError pulse at CS rise; no second write.
REQ-036 i_Reset asserted for 2 cycles after bit 10 while CS stays low and SCK keeps toggling -> no write and no error until CS rises; the following frame 0xC1_0342 writes number 0xC103, value 0x42.
REQ-037 i_SampleReady with i_Sample=0x1234 in the same cycle as the detected CS fall (hold register=0x7FFF) -> MISO shifts out 0x1234.

Source files
------------

// File: rtl/spi_register_bridge_if.sv
// Signal bundle between the SPI host / synthesizer core and the register bridge.
// The slave modport is the bridge's view; the master modport is the view of whatever drives it.
interface spi_register_bridge_if;
  logic        i_SPI_SCK;
  logic        i_SPI_CS_n;
  logic        i_SPI_MOSI;
  logic        o_SPI_MISO;
  logic [15:0] i_Sample;
  logic        i_SampleReady;
  logic        o_RegisterWriteEnable;
  logic [15:0] o_RegisterWriteNumber;
  logic [7:0]  o_RegisterWriteValue;
  logic        o_FrameError;

  modport slave (
    input  i_SPI_SCK,
    input  i_SPI_CS_n,
    input  i_SPI_MOSI,
    output o_SPI_MISO,
    input  i_Sample,
    input  i_SampleReady,
    output o_RegisterWriteEnable,
    output o_RegisterWriteNumber,
    output o_RegisterWriteValue,
    output o_FrameError
  );

  modport master (
    output i_SPI_SCK,
    output i_SPI_CS_n,
    output i_SPI_MOSI,
    input  o_SPI_MISO,
    output i_Sample,
    output i_SampleReady,
    input  o_RegisterWriteEnable,
    input  o_RegisterWriteNumber,
    input  o_RegisterWriteValue,
    input  o_FrameError
  );
endinterface

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave that turns 24-bit host frames into synthesizer register writes
// and streams the latest audio sample back to the host on MISO.
module spi_register_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  spi_register_bridge_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_CS_HIGH} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] sync_valid;
  logic                   sck_prev;
  logic                   cs_prev;
  logic                   sck_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_rise;
  logic                   cs_fall;
  logic [15:0]            sample_hold;
  logic [15:0]            miso_shift;
  logic [4:0]             bit_count;
  logic [22:0]            shift_reg;
  logic [23:0]            shift_next;
  logic                   overrun;
  logic                   write_enable;
  logic                   frame_error;
  logic [15:0]            write_number;
  logic [7:0]             write_value;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;
  assign sck_fall = ~sck_s & sck_prev;
  assign cs_rise  = cs_s & ~cs_prev;
  assign cs_fall  = ~cs_s & cs_prev;

  // Only 23 bits are stored: the 24th bit goes straight into the write value.
  assign shift_next = {shift_reg, mosi_s};

  // sync_valid marks when the last synchronizer stage holds a real pin sample
  // rather than its reset value, so WAIT_CS_HIGH cannot be fooled by reset.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sck_sync   <= '0;
      cs_sync    <= '1;
      mosi_sync  <= '0;
      sync_valid <= '0;
      sck_prev   <= 1'b0;
      cs_prev    <= 1'b1;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], bus.i_SPI_SCK};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], bus.i_SPI_CS_n};
      mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], bus.i_SPI_MOSI};
      sync_valid <= {sync_valid[SYNC_STAGES-2:0], 1'b1};
      sck_prev   <= sck_s;
      cs_prev    <= cs_s;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sample_hold <= '0;
    end else if (bus.i_SampleReady) begin
      sample_hold <= bus.i_Sample;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state        <= WAIT_CS_HIGH;
      bit_count    <= '0;
      shift_reg    <= '0;
      miso_shift   <= '0;
      overrun      <= 1'b0;
      write_enable <= 1'b0;
      frame_error  <= 1'b0;
      write_number <= '0;
      write_value  <= '0;
    end else begin
      write_enable <= 1'b0;
      frame_error  <= 1'b0;
      if (((state == SHIFT) || (state == DONE)) && sck_fall) begin
        miso_shift <= {miso_shift[14:0], 1'b0};
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state      <= SHIFT;
            bit_count  <= '0;
            overrun    <= 1'b0;
            miso_shift <= bus.i_SampleReady ? bus.i_Sample : sample_hold;
          end
        end
        SHIFT: begin
          // A CS rise wins over a simultaneous SCK rise; that bit is dropped.
          if (cs_rise) begin
            frame_error <= 1'b1;
            state       <= IDLE;
          end else if (sck_rise) begin
            shift_reg <= shift_next[22:0];
            bit_count <= bit_count + 5'd1;
            if (bit_count == 5'd23) begin
              state        <= DONE;
              write_enable <= 1'b1;
              write_number <= shift_next[23:8];
              write_value  <= shift_next[7:0];
            end
          end
        end
        DONE: begin
          if (cs_rise) begin
            frame_error <= overrun;
            overrun     <= 1'b0;
            state       <= IDLE;
          end else if (sck_rise) begin
            overrun <= 1'b1;
          end
        end
        WAIT_CS_HIGH: begin
          if (sync_valid[SYNC_STAGES-1] && cs_s) begin
            state <= IDLE;
          end
        end
        default: state <= WAIT_CS_HIGH;
      endcase
    end
  end

  assign bus.o_SPI_MISO            = ((state == SHIFT) || (state == DONE)) && miso_shift[15];
  assign bus.o_RegisterWriteEnable = write_enable;
  assign bus.o_RegisterWriteNumber = write_number;
  assign bus.o_RegisterWriteValue  = write_value;
  assign bus.o_FrameError          = frame_error;

endmodule
